decoder_3to8: RTL and testbench
===============================

# decoder_3to8

Registered 3-to-8 line decoder with enable, used wherever a 3-bit select must fan out to eight one-hot strobes (chip selects, bank enables, write strobes). Three scalar select inputs form an index; on each clock edge the corresponding output line is asserted if enabled. An optional per-line hit-counter bank supports debug and performance observation.

## Interface
Parameters:
- OUT_ACTIVE_LOW, 0: 0 = asserted line is 1, others 0; 1 = all bits of `i` inverted (asserted line 0).
- CNT_W, 8: width of each hit counter (only used with DECODER_HIT_CNT_EN); legal 1..32.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- a  input  1  select bit 2 (MSB).
- b  input  1  select bit 1.
- c  input  1  select bit 0 (LSB).
- enb  input  1  enable; 1 = decode, 0 = all lines inactive.
- i  output  8  registered one-hot decode; bit n asserted when index {a,b,c} == n and enb was 1.
- vld  output  1  registered copy of enb; 1 when `i` holds a decoded line.
- cnt_sel  input  3  hit-counter read select (DECODER_HIT_CNT_EN only).
- cnt_clr  input  1  synchronous clear of all hit counters (DECODER_HIT_CNT_EN only).
- cnt_q  output  CNT_W  value of hit counter selected by cnt_sel (DECODER_HIT_CNT_EN only).

## Operation
- Index idx = {a,b,c}, a is MSB; range 0..7.
- enb=1 at rising edge: i <= (8'b1 << idx), vld <= 1.
- enb=0 at rising edge: i <= 8'h00, vld <= 0.
- OUT_ACTIVE_LOW=1: the 8-bit value above is bitwise-inverted before registering (inactive = 8'hFF); vld polarity unchanged.
- Exactly one bit of `i` is asserted whenever vld=1; no bit asserted whenever vld=0.
- Select/enable X or Z are not supported; inputs must be driven 0/1.
- No internal state other than `i`, `vld` and (when compiled in) the counter bank.

## Timing
- Latency: 1 clock from inputs sampled at edge N to `i`/`vld` valid after edge N; inputs may change every cycle, each cycle decoded independently.
- Reset (rst=1 at edge): i <= 8'h00 (8'hFF if OUT_ACTIVE_LOW=1), vld <= 0, all counters <= 0. Reset has priority over enb, selects and cnt_clr.
- Reset mid-operation: the output produced on the reset edge is the reset value regardless of inputs; decoding resumes on the first edge with rst=0.
- No combinational path from a/b/c/enb to i/vld.
- Counters (when present): at an edge with rst=0, cnt_clr=0, enb=1, counter[idx] increments by 1; saturates at 2^CNT_W-1 (no wrap). cnt_clr=1 clears all counters; cnt_clr and an increment on the same edge: clear wins, counter ends at 0.
- cnt_q is combinational from cnt_sel and the counter registers (reflects counts as of the last edge).

## Configuration
- Macro DECODER_HIT_CNT_EN.
- Defined: eight CNT_W-bit saturating hit counters, ports cnt_sel, cnt_clr, cnt_q present, behaviour as in Timing.
- Undefined: counter bank, cnt_sel, cnt_clr and cnt_q are absent from the module; decode behaviour of i/vld is identical.

## Test plan
- Reset: rst=1 for 2 edges with enb=1, {a,b,c}=3'b101 -> i=8'h00, vld=0 after each edge.
- Sweep: rst=0, enb=1, {a,b,c}=k for k=0..7, one per clock -> one edge later i=8'h01,02,04,08,10,20,40,80 in order, vld=1.
- Disable: enb=0 with {a,b,c}=3'b011 -> i=8'h00, vld=0; re-assert enb=1 -> i=8'h08 one edge later.
- Active-low build (OUT_ACTIVE_LOW=1): reset -> i=8'hFF; enb=1, idx=2 -> i=8'hFB.
- Counters (DECODER_HIT_CNT_EN, CNT_W=2): idx=6 enabled 5 consecutive cycles -> cnt_sel=6 gives cnt_q=3 (saturated), cnt_sel=5 gives 0; cnt_clr=1 with enb=1 idx=6 -> cnt_q=0 next cycle.
- Mid-run reset: sweep running, rst=1 for one edge at idx=4 -> i=8'h00, counters 0; next edge with rst=0, idx=5 -> i=8'h20.

Source files
------------

// File: rtl/decoder_3to8.sv
// Registered 3-to-8 one-hot decoder with enable and optional polarity inversion.
// Define DECODER_HIT_CNT_EN to add eight saturating per-line hit counters with a read mux.
module decoder_3to8 #(
  parameter int OUT_ACTIVE_LOW = 0,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             enb,
  output logic [7:0]       i,
  output logic             vld
`ifdef DECODER_HIT_CNT_EN
  ,
  input  logic [2:0]       cnt_sel,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt_q
`endif
);

  // XOR mask applied to the one-hot value; also the idle/reset value of i.
  localparam logic [7:0] INACTIVE = (OUT_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

  logic [2:0] idx;
  logic [7:0] dec;
  logic [7:0] i_d, i_q;
  logic       vld_d, vld_q;

  assign idx = {a, b, c};

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_dec
      assign dec[gi] = enb && (idx == 3'(gi));
    end
  endgenerate

  always_comb begin
    i_d   = dec ^ INACTIVE;
    vld_d = enb;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i_q   <= INACTIVE;
      vld_q <= 1'b0;
    end else begin
      i_q   <= i_d;
      vld_q <= vld_d;
    end
  end

  assign i   = i_q;
  assign vld = vld_q;

`ifdef DECODER_HIT_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] hit_all [8];

  generate
    for (gi = 0; gi < 8; gi++) begin : g_cnt
      logic [CNT_W-1:0] hit_d, hit_q;

      // Clear beats a same-edge hit; a full counter holds rather than wrapping.
      always_comb begin
        hit_d = hit_q;
        if (cnt_clr)
          hit_d = '0;
        else if (dec[gi] && (hit_q != CNT_MAX))
          hit_d = hit_q + CNT_W'(1);
      end

      always_ff @(posedge clk) begin
        if (rst)
          hit_q <= '0;
        else
          hit_q <= hit_d;
      end

      assign hit_all[gi] = hit_q;
    end
  endgenerate

  assign cnt_q = hit_all[cnt_sel];
`endif

endmodule

// File: tb/tb_decoder_3to8.sv
// Scoreboard bench for decoder_3to8: active-high and active-low instances share stimulus;
// counter checks are compiled in only when DECODER_HIT_CNT_EN is defined.
module tb_decoder_3to8;

  typedef struct {
    logic [7:0] ei;
    logic       ev;
    logic [7:0] eal;
    bit         chk;
    logic [1:0] ecnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a = 1'b0, b = 1'b0, c = 1'b0;
  logic       enb = 1'b0;
  logic [7:0] i_hi, i_al;
  logic       vld_hi, vld_al;
  logic [2:0] cnt_sel = 3'd0;
  logic       cnt_clr = 1'b0;
  logic [1:0] cnt_hi, cnt_al;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  logic [7:0] sweep_hi [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
  logic [7:0] sweep_al [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

  always #5 clk = ~clk;

  decoder_3to8 #(.OUT_ACTIVE_LOW(0), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .enb(enb),
    .i(i_hi), .vld(vld_hi)
`ifdef DECODER_HIT_CNT_EN
    , .cnt_sel(cnt_sel), .cnt_clr(cnt_clr), .cnt_q(cnt_hi)
`endif
  );

  decoder_3to8 #(.OUT_ACTIVE_LOW(1), .CNT_W(2)) dut_al (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .enb(enb),
    .i(i_al), .vld(vld_al)
`ifdef DECODER_HIT_CNT_EN
    , .cnt_sel(cnt_sel), .cnt_clr(cnt_clr), .cnt_q(cnt_al)
`endif
  );

`ifndef DECODER_HIT_CNT_EN
  assign cnt_hi = 2'd0;
  assign cnt_al = 2'd0;
`endif

  // Drive one cycle of stimulus at the falling edge and queue what must appear after the next rising edge.
  task automatic step(input logic r, input logic e, input int idx, input logic clr,
                      input int sel, input logic [7:0] ei, input logic ev,
                      input logic [7:0] eal, input bit chk, input logic [1:0] ecnt);
    exp_t x;
    @(negedge clk);
    rst     = r;
    enb     = e;
    {a, b, c} = 3'(idx);
    cnt_clr = clr;
    cnt_sel = 3'(sel);
    x.ei = ei; x.ev = ev; x.eal = eal; x.chk = chk; x.ecnt = ecnt;
    sb_q.push_back(x);
    $display("stim: rst=%0b enb=%0b idx=%0d clr=%0b sel=%0d -> exp i=%02h vld=%0b i_al=%02h",
             r, e, idx, clr, sel, ei, ev, eal);
  endtask

  // Monitor: one queued expectation per rising edge, sampled 1 time unit after it.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
        x = sb_q.pop_front();
        checks++;
        if (i_hi !== x.ei) begin
          errors++;
          $display("FAIL i: got %02h expected %02h", i_hi, x.ei);
        end
        checks++;
        if (vld_hi !== x.ev) begin
          errors++;
          $display("FAIL vld: got %0b expected %0b", vld_hi, x.ev);
        end
        checks++;
        if (i_al !== x.eal) begin
          errors++;
          $display("FAIL i_al: got %02h expected %02h", i_al, x.eal);
        end
        checks++;
        if (vld_al !== x.ev) begin
          errors++;
          $display("FAIL vld_al: got %0b expected %0b", vld_al, x.ev);
        end
`ifdef DECODER_HIT_CNT_EN
        if (x.chk) begin
          checks++;
          if (cnt_hi !== x.ecnt) begin
            errors++;
            $display("FAIL cnt_q sel=%0d: got %0d expected %0d", cnt_sel, cnt_hi, x.ecnt);
          end
          checks++;
          if (cnt_al !== x.ecnt) begin
            errors++;
            $display("FAIL cnt_q_al sel=%0d: got %0d expected %0d", cnt_sel, cnt_al, x.ecnt);
          end
        end
`endif
      end
    end
  end

  initial begin
    int wait_cycles;
    // Reset held two edges while enabled with idx=5.
    step(1, 1, 5, 0, 0, 8'h00, 0, 8'hFF, 1, 2'd0);
    step(1, 1, 5, 0, 5, 8'h00, 0, 8'hFF, 1, 2'd0);
    // Sweep; each counter reaches 1.
    for (int k = 0; k < 8; k++)
      step(0, 1, k, 0, k, sweep_hi[k], 1, sweep_al[k], 1, 2'd1);
    // Disable, then re-enable idx=3 (counter 3 -> 2), then idx=2.
    step(0, 0, 3, 0, 3, 8'h00, 0, 8'hFF, 1, 2'd1);
    step(0, 1, 3, 0, 3, 8'h08, 1, 8'hF7, 1, 2'd2);
    step(0, 1, 2, 0, 2, 8'h04, 1, 8'hFB, 1, 2'd2);
    // Clear all counters while idle.
    step(0, 0, 0, 1, 3, 8'h00, 0, 8'hFF, 1, 2'd0);
    // idx=6 for five cycles: 1,2,3 then saturated at 3.
    step(0, 1, 6, 0, 6, 8'h40, 1, 8'hBF, 1, 2'd1);
    step(0, 1, 6, 0, 6, 8'h40, 1, 8'hBF, 1, 2'd2);
    step(0, 1, 6, 0, 6, 8'h40, 1, 8'hBF, 1, 2'd3);
    step(0, 1, 6, 0, 6, 8'h40, 1, 8'hBF, 1, 2'd3);
    step(0, 1, 6, 0, 6, 8'h40, 1, 8'hBF, 1, 2'd3);
    step(0, 0, 6, 0, 5, 8'h00, 0, 8'hFF, 1, 2'd0);
    // Clear wins over a same-edge hit.
    step(0, 1, 6, 1, 6, 8'h40, 1, 8'hBF, 1, 2'd0);
    // Mid-run reset at idx=4 after counting idx 0..3 once.
    step(0, 1, 0, 0, 0, 8'h01, 1, 8'hFE, 1, 2'd1);
    step(0, 1, 1, 0, 0, 8'h02, 1, 8'hFD, 1, 2'd1);
    step(0, 1, 2, 0, 0, 8'h04, 1, 8'hFB, 1, 2'd1);
    step(0, 1, 3, 0, 0, 8'h08, 1, 8'hF7, 1, 2'd1);
    step(1, 1, 4, 0, 0, 8'h00, 0, 8'hFF, 1, 2'd0);
    step(0, 1, 5, 0, 5, 8'h20, 1, 8'hDF, 1, 2'd1);
    step(0, 1, 7, 0, 4, 8'h80, 1, 8'h7F, 1, 2'd0);

    wait_cycles = 0;
    while (sb_q.size() != 0 && wait_cycles < 20) begin
      @(posedge clk);
      wait_cycles++;
    end
    #2;
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
